// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions for the receiver and the transmitter:
//            the receiver state encoding, default frame timing and the
//            line levels of the start and stop bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DANE   = 3'd2,
    STOP   = 3'd3,
    CZEKAJ = 3'd4
  } uart_stan_t;

  // Default timing: clock cycles per bit, data bits per frame.
  localparam int c_oversample_def = 16;
  localparam int c_szer_def       = 8;

  // Line levels of the framing bits (idle line is high).
  localparam logic c_bit_start = 1'b0;
  localparam logic c_bit_stop  = 1'b1;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_synchronizator.sv
// ============================================================================
// Module   : uart_synchronizator
// Purpose  : Two-flop synchroniser bringing an asynchronous input into the
//            clk domain. Both flops reset to RST_VAL so that an idle-high
//            line does not look like activity right after reset.
// Ports    : clk      - destination clock
//            rst_n    - asynchronous active-low reset
//            i_async  - asynchronous input
//            o_sync   - synchronised output (two clock cycles of delay)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_synchronizator #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule : uart_synchronizator

`default_nettype wire

// File: rtl/uart_odbiornik.sv
// ============================================================================
// Module   : uart_odbiornik
// Purpose  : Oversampling UART receiver (8N1 by default, LSB first, idle
//            high). Recovers words with start/stop checks and offers them
//            to the consumer through a level valid / acknowledge handshake.
//            OVERSAMPLE must be even and at least 4.
// Ports    : CLK           - system clock, rising edge
//            RST_n         - asynchronous active-low reset
//            wejscie_odb   - asynchronous serial line, idle 1
//            potwierdz     - consumer acknowledge, clears odebrano
//            slowo_odb     - last correctly received word
//            odebrano      - slowo_odb holds an unacknowledged word
//            odbior        - a frame is in progress
//            blad_ramki    - one-cycle pulse, stop bit sampled low
//            przepelnienie - one-cycle pulse, word overwrote an unread one
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_odbiornik
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_oversample_def,
  parameter int SZER       = c_szer_def
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            wejscie_odb,
  input  logic            potwierdz,
  output logic [SZER-1:0] slowo_odb,
  output logic            odebrano,
  output logic            odbior,
  output logic            blad_ramki,
  output logic            przepelnienie
);

  localparam int LW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(SZER + 1);

  // Start check lands mid start bit; data/stop samples one full bit later.
  localparam logic [LW-1:0] c_polowa  = LW'(OVERSAMPLE / 2 - 1);
  localparam logic [LW-1:0] c_pelny   = LW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] c_ostatni = NW'(SZER - 1);

  logic rx;

  uart_synchronizator #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (CLK),
    .rst_n   (RST_n),
    .i_async (wejscie_odb),
    .o_sync  (rx)
  );

  uart_stan_t      stan_q, stan_d;
  logic [LW-1:0]   licznik_q, licznik_d;
  logic [NW-1:0]   nr_bitu_q, nr_bitu_d;
  logic [SZER-1:0] rejestr_q, rejestr_d;
  logic [SZER-1:0] slowo_q, slowo_d;
  logic            odebrano_q, odebrano_d;
  logic            blad_q, blad_d;
  logic            przep_q, przep_d;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stan_q     <= IDLE;
      licznik_q  <= '0;
      nr_bitu_q  <= '0;
      rejestr_q  <= '0;
      slowo_q    <= '0;
      odebrano_q <= 1'b0;
      blad_q     <= 1'b0;
      przep_q    <= 1'b0;
    end else begin
      stan_q     <= stan_d;
      licznik_q  <= licznik_d;
      nr_bitu_q  <= nr_bitu_d;
      rejestr_q  <= rejestr_d;
      slowo_q    <= slowo_d;
      odebrano_q <= odebrano_d;
      blad_q     <= blad_d;
      przep_q    <= przep_d;
    end
  end

  always_comb begin
    stan_d     = stan_q;
    licznik_d  = licznik_q;
    nr_bitu_d  = nr_bitu_q;
    rejestr_d  = rejestr_q;
    slowo_d    = slowo_q;
    odebrano_d = odebrano_q;
    blad_d     = 1'b0;
    przep_d    = 1'b0;

    // Acknowledge clears the flag; a same-cycle load below overrides it.
    if (potwierdz) begin
      odebrano_d = 1'b0;
    end

    case (stan_q)
      IDLE: begin
        if (rx == c_bit_start) begin
          stan_d    = START;
          licznik_d = '0;
        end
      end

      START: begin
        if (licznik_q == c_polowa) begin
          licznik_d = '0;
          // A line that is high again mid start bit was only a glitch.
          if (rx == c_bit_start) begin
            stan_d    = DANE;
            nr_bitu_d = '0;
          end else begin
            stan_d = IDLE;
          end
        end else begin
          licznik_d = licznik_q + 1'b1;
        end
      end

      DANE: begin
        if (licznik_q == c_pelny) begin
          licznik_d = '0;
          // LSB arrives first, so shifting in at the MSB ends LSB-aligned.
          rejestr_d = {rx, rejestr_q[SZER-1:1]};
          nr_bitu_d = nr_bitu_q + 1'b1;
          if (nr_bitu_q == c_ostatni) begin
            stan_d = STOP;
          end
        end else begin
          licznik_d = licznik_q + 1'b1;
        end
      end

      STOP: begin
        if (licznik_q == c_pelny) begin
          licznik_d = '0;
          if (rx == c_bit_stop) begin
            slowo_d    = rejestr_q;
            odebrano_d = 1'b1;
            przep_d    = odebrano_q & ~potwierdz;
            // Leaving mid stop bit lets a back-to-back start bit be caught.
            stan_d     = IDLE;
          end else begin
            blad_d = 1'b1;
            stan_d = CZEKAJ;
          end
        end else begin
          licznik_d = licznik_q + 1'b1;
        end
      end

      CZEKAJ: begin
        // Hold off a held-low (break) line so it reports one error only.
        if (rx == c_bit_stop) begin
          stan_d = IDLE;
        end
      end

      default: begin
        stan_d = IDLE;
      end
    endcase
  end

  assign slowo_odb     = slowo_q;
  assign odebrano      = odebrano_q;
  assign odbior        = (stan_q != IDLE);
  assign blad_ramki    = blad_q;
  assign przepelnienie = przep_q;

endmodule : uart_odbiornik

`default_nettype wire

// File: tb/tb_uart_odbiornik.sv
// ============================================================================
// Module   : tb_uart_odbiornik
// Purpose  : Self-checking bench for uart_odbiornik at the default timing
//            (16 cycles per bit, 8 data bits). Directed sequences for the
//            timing-sensitive corners, then a table of frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_odbiornik;

  logic       CLK;
  logic       RST_n;
  logic       wejscie_odb;
  logic       potwierdz;
  logic [7:0] slowo_odb;
  logic       odebrano;
  logic       odbior;
  logic       blad_ramki;
  logic       przepelnienie;

  int checks = 0;
  int errors = 0;
  int n_blad = 0;
  int n_przep = 0;

  uart_odbiornik #(
    .OVERSAMPLE (16),
    .SZER       (8)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .wejscie_odb   (wejscie_odb),
    .potwierdz     (potwierdz),
    .slowo_odb     (slowo_odb),
    .odebrano      (odebrano),
    .odbior        (odbior),
    .blad_ramki    (blad_ramki),
    .przepelnienie (przepelnienie)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulses last one cycle, so counting on the falling edge sees each once.
  always @(negedge CLK) begin
    if (blad_ramki === 1'b1) n_blad++;
    if (przepelnienie === 1'b1) n_przep++;
  end

  typedef struct {
    logic [7:0] dane;
    logic       stop;
    logic       ack_przed;
    logic [7:0] exp_slowo;
    logic       exp_odebrano;
    int         exp_blad;
    int         exp_przep;
  } wektor_t;

  wektor_t tabela [8];

  task automatic check(input string nazwa, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nazwa, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ack_pulse();
    potwierdz = 1'b1;
    @(negedge CLK);
    potwierdz = 1'b0;
  endtask

  // Drives one frame from a falling edge; edge 0 is the next rising edge.
  // ack_at raises potwierdz for exactly that edge (-1: never). The line is
  // left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at,
                            input bit chk, input logic odb_przed);
    logic [9:0] ramka;
    ramka       = {stop, d, 1'b0};
    wejscie_odb = ramka[0];
    potwierdz   = (ack_at == 0);
    for (int e = 0; e < 160; e++) begin
      @(negedge CLK);
      wejscie_odb = (e + 1 < 160) ? ramka[(e + 1) / 16] : stop;
      potwierdz   = (e + 1 == ack_at);
      if (chk && e == 153) begin
        check("lat_odebrano_e153", {31'd0, odebrano}, {31'd0, odb_przed});
        check("lat_odbior_e153", {31'd0, odbior}, 32'd1);
        check("lat_blad_e153", {31'd0, blad_ramki}, 32'd0);
      end
      if (chk && e == 154) begin
        if (stop) begin
          check("lat_odebrano_e154", {31'd0, odebrano}, 32'd1);
          check("lat_odbior_e154", {31'd0, odbior}, 32'd0);
        end else begin
          check("lat_blad_e154", {31'd0, blad_ramki}, 32'd1);
          check("lat_odbior_blad_e154", {31'd0, odbior}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    int         b0, p0;
    logic [7:0] slowo0;
    logic       odeb0;
    logic [15:0] maska;

    tabela[0] = '{8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 0, 0};
    tabela[1] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 0, 0};
    tabela[2] = '{8'hA5, 1'b0, 1'b0, 8'h5A, 1'b1, 1, 0};
    tabela[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1};
    tabela[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
    tabela[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1};
    tabela[6] = '{8'h81, 1'b0, 1'b1, 8'hFF, 1'b0, 1, 0};
    tabela[7] = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 0, 0};

    // Reset state
    RST_n       = 1'b0;
    wejscie_odb = 1'b1;
    potwierdz   = 1'b0;
    idle(3);
    check("rst_slowo", {24'd0, slowo_odb}, 32'd0);
    check("rst_odebrano", {31'd0, odebrano}, 32'd0);
    check("rst_odbior", {31'd0, odbior}, 32'd0);
    check("rst_blad", {31'd0, blad_ramki}, 32'd0);
    check("rst_przep", {31'd0, przepelnienie}, 32'd0);
    RST_n = 1'b1;
    idle(4);

    // 0x99 with latency check at edges 153/154
    send_frame(8'h99, 1'b1, -1, 1'b1, 1'b0);
    idle(2);
    check("a_slowo", {24'd0, slowo_odb}, 32'h99);
    check("a_blad_cnt", n_blad, 32'd0);

    // Back-to-back, acknowledged in between: no overrun
    ack_pulse();
    p0 = n_przep;
    send_frame(8'h99, 1'b1, -1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 10, 1'b0, 1'b0);
    idle(2);
    check("b2b_ack_slowo", {24'd0, slowo_odb}, 32'h5A);
    check("b2b_ack_odebrano", {31'd0, odebrano}, 32'd1);
    check("b2b_ack_przep", n_przep - p0, 32'd0);

    // Back-to-back without acknowledge: exactly one overrun
    ack_pulse();
    p0 = n_przep;
    send_frame(8'h99, 1'b1, -1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b0);
    idle(2);
    check("b2b_noack_slowo", {24'd0, slowo_odb}, 32'h5A);
    check("b2b_noack_przep", n_przep - p0, 32'd1);

    // 4-cycle low glitch: odbior high after edges 2..9 only
    b0     = n_blad;
    p0     = n_przep;
    slowo0 = slowo_odb;
    odeb0  = odebrano;
    maska  = '0;
    wejscie_odb = 1'b0;
    for (int e = 0; e < 16; e++) begin
      @(negedge CLK);
      if (e == 3) wejscie_odb = 1'b1;
      maska[e] = odbior;
    end
    check("glitch_odbior_mask", {16'd0, maska}, 32'h03FC);
    check("glitch_slowo", {24'd0, slowo_odb}, {24'd0, slowo0});
    check("glitch_odebrano", {31'd0, odebrano}, {31'd0, odeb0});
    check("glitch_flags", (n_blad - b0) + (n_przep - p0), 32'd0);

    // 0xA5 with stop bit low, line held low 40 more cycles (break)
    b0 = n_blad;
    send_frame(8'hA5, 1'b0, -1, 1'b1, 1'b1);
    idle(40);
    check("brk_odbior_low", {31'd0, odbior}, 32'd1);
    wejscie_odb = 1'b1;
    idle(5);
    check("brk_odbior_back", {31'd0, odbior}, 32'd0);
    check("brk_blad_cnt", n_blad - b0, 32'd1);
    check("brk_slowo", {24'd0, slowo_odb}, 32'h5A);

    // Reset asserted in data bit 4 of 0xFF
    wejscie_odb = 1'b0;
    idle(16);
    wejscie_odb = 1'b1;
    idle(69);
    check("rstmid_busy", {31'd0, odbior}, 32'd1);
    RST_n = 1'b0;
    #1;
    check("rstmid_odbior", {31'd0, odbior}, 32'd0);
    check("rstmid_odebrano", {31'd0, odebrano}, 32'd0);
    check("rstmid_slowo", {24'd0, slowo_odb}, 32'd0);
    idle(3);
    RST_n = 1'b1;
    idle(4);
    b0 = n_blad;
    send_frame(8'h3C, 1'b1, -1, 1'b0, 1'b0);
    idle(2);
    check("rstmid_3c_slowo", {24'd0, slowo_odb}, 32'h3C);
    check("rstmid_3c_odebrano", {31'd0, odebrano}, 32'd1);
    check("rstmid_3c_blad", n_blad - b0, 32'd0);

    // Acknowledge on the load edge of 0x11: load wins, no overrun
    p0 = n_przep;
    send_frame(8'h11, 1'b1, 154, 1'b1, 1'b1);
    check("same_slowo", {24'd0, slowo_odb}, 32'h11);
    check("same_przep", n_przep - p0, 32'd0);
    ack_pulse();
    check("same_ack_clears", {31'd0, odebrano}, 32'd0);
    idle(3);

    // Table of frames
    for (int i = 0; i < 8; i++) begin
      b0 = n_blad;
      p0 = n_przep;
      if (tabela[i].ack_przed) ack_pulse();
      send_frame(tabela[i].dane, tabela[i].stop, -1, 1'b0, 1'b0);
      wejscie_odb = 1'b1;
      idle(4);
      check($sformatf("tab%0d_slowo", i), {24'd0, slowo_odb}, {24'd0, tabela[i].exp_slowo});
      check($sformatf("tab%0d_odebrano", i), {31'd0, odebrano}, {31'd0, tabela[i].exp_odebrano});
      check($sformatf("tab%0d_blad", i), n_blad - b0, tabela[i].exp_blad);
      check($sformatf("tab%0d_przep", i), n_przep - p0, tabela[i].exp_przep);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_odbiornik

`default_nettype wire
